// File: rtl/forward_unit.sv
// forward_unit: EX-stage operand forwarding selects and load-use stall detection (optional stall counter via FWD_STALL_CNT_EN)
module forward_unit #(
  parameter int REG_W = 5
`ifdef FWD_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_valid_i,
  input  logic [REG_W-1:0] ex_rs_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             flush_i,
  output logic [1:0]       fwdA_sel_o,
  output logic [1:0]       fwdB_sel_o,
  output logic             stall_o
`ifdef FWD_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  logic [REG_W-1:0] r_mem_rd;
  logic             r_mem_we;
  logic [REG_W-1:0] r_wb_rd;
  logic             r_wb_we;
  logic             w_ex_live;
  logic             w_a_mem;
  logic             w_a_wb;
  logic             w_b_mem;
  logic             w_b_wb;

  // a flushed or bubble instruction enters MEM as a non-writing slot
  assign w_ex_live = ex_valid_i & ~flush_i;

  // MEM and WB slots shift every cycle; a stall bubbles EX, never MEM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem_rd <= '0;
      r_mem_we <= 1'b0;
      r_wb_rd  <= '0;
      r_wb_we  <= 1'b0;
    end else begin
      r_wb_rd  <= r_mem_rd;
      r_wb_we  <= r_mem_we;
      r_mem_rd <= ex_rd_i;
      r_mem_we <= ex_regwrite_i & w_ex_live;
    end
  end

  // register 0 is hardwired, so a match on it never forwards
  assign w_a_mem = (ex_rs_i != '0) & r_mem_we & (r_mem_rd == ex_rs_i);
  assign w_a_wb  = (ex_rs_i != '0) & r_wb_we  & (r_wb_rd  == ex_rs_i);
  assign w_b_mem = (ex_rt_i != '0) & r_mem_we & (r_mem_rd == ex_rt_i);
  assign w_b_wb  = (ex_rt_i != '0) & r_wb_we  & (r_wb_rd  == ex_rt_i);

  // newest producer wins: MEM result takes priority over WB result
  always_comb begin
    fwdA_sel_o = w_a_mem ? 2'd1 : w_a_wb ? 2'd2 : 2'd0;
    fwdB_sel_o = w_b_mem ? 2'd1 : w_b_wb ? 2'd2 : 2'd0;
  end

  // load in EX feeding the instruction in ID needs one bubble; flush and reset suppress it
  always_comb begin
    stall_o = ~rst_i & w_ex_live & ex_memread_i & ex_regwrite_i & (ex_rd_i != '0) &
              ((ex_rd_i == id_rs_i) | (ex_rd_i == id_rt_i));
  end

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // saturating count of stall cycles, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_stall_cnt <= '0;
    else if (stall_o && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_forward_unit.sv
// tb_forward_unit: directed and randomized checks of forward_unit against a pipeline-history model
module tb_forward_unit;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       ex_valid_i;
  logic [4:0] ex_rs_i, ex_rt_i, ex_rd_i;
  logic       ex_regwrite_i, ex_memread_i;
  logic [4:0] id_rs_i, id_rt_i;
  logic       flush_i;
  logic [1:0] fwdA_sel_o, fwdB_sel_o;
  logic       stall_o;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  forward_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .ex_valid_i(ex_valid_i),
    .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i), .ex_rd_i(ex_rd_i),
    .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .flush_i(flush_i),
    .fwdA_sel_o(fwdA_sel_o), .fwdB_sel_o(fwdB_sel_o), .stall_o(stall_o)
`ifdef FWD_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int rd; bit we; bit ld; } slot_t;
  slot_t hist[$];
  int    cnt_m = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_prot = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_sel(input int src);
    if (src == 0) return 0;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].we && hist[i].rd == src) return i + 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    return !rst_i && ex_valid_i && !flush_i && ex_memread_i && ex_regwrite_i &&
           ex_rd_i != 0 && (ex_rd_i == id_rs_i || ex_rd_i == id_rt_i);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".selA"}, fwdA_sel_o, exp_sel(ex_rs_i));
    check({tag, ".selB"}, fwdB_sel_o, exp_sel(ex_rt_i));
    check({tag, ".stall"}, stall_o, exp_stall());
`ifdef FWD_STALL_CNT_EN
    check({tag, ".cnt"}, stall_cnt_o, cnt_m);
`endif
    if (hist.size() > 0 && hist[0].ld && hist[0].rd != 0 &&
        (hist[0].rd == ex_rs_i || hist[0].rd == ex_rt_i)) n_prot++;
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input int rd,
                       input bit we, input bit ld, input int irs, input int irt,
                       input bit f, input string tag);
    ex_valid_i = v; ex_rs_i = 5'(rs); ex_rt_i = 5'(rt); ex_rd_i = 5'(rd);
    ex_regwrite_i = we; ex_memread_i = ld; id_rs_i = 5'(irs); id_rt_i = 5'(irt);
    flush_i = f;
    @(negedge clk_i);
    check_all(tag);
  endtask

  task automatic adv();
    bit st;
    st = exp_stall();
    @(posedge clk_i);
    if (!rst_i) begin
      hist.push_front('{rd: int'(ex_rd_i), we: ex_regwrite_i & ex_valid_i & ~flush_i,
                        ld: ex_memread_i & ex_valid_i & ~flush_i});
      if (hist.size() > 2) void'(hist.pop_back());
      if (st && cnt_m < 65535) cnt_m++;
    end
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "nop");
      adv();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    ex_valid_i = 0; ex_rs_i = 0; ex_rt_i = 0; ex_rd_i = 0; ex_regwrite_i = 0;
    ex_memread_i = 0; id_rs_i = 0; id_rt_i = 0; flush_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    drive(1, 3, 3, 3, 1, 1, 3, 3, 0, "in_reset");
    check("reset_stall", stall_o, 0);
    adv();
    rst_i = 1'b0;
    nops(2);

    drive(1, 1, 2, 3, 1, 0, 3, 5, 0, "add_r3");
    adv();
    drive(1, 3, 5, 4, 1, 0, 0, 0, 0, "sub_mem");
    check("add_sub_A_mem", fwdA_sel_o, 1);
    adv();
    nops(2);

    drive(1, 1, 2, 3, 1, 0, 0, 0, 0, "add_r3b");
    adv();
    nops(1);
    drive(1, 3, 5, 4, 1, 0, 0, 0, 0, "sub_wb");
    check("add_nop_sub_A_wb", fwdA_sel_o, 2);
    adv();
    nops(2);

    drive(1, 1, 2, 3, 1, 0, 0, 0, 0, "wr_r3_old");
    adv();
    drive(1, 6, 7, 3, 1, 0, 0, 0, 0, "wr_r3_new");
    adv();
    drive(1, 8, 3, 9, 1, 0, 0, 0, 0, "rd_r3_rt");
    check("both_match_B_mem", fwdB_sel_o, 1);
    adv();
    nops(2);

    drive(1, 1, 0, 2, 1, 1, 2, 6, 0, "lw_r2");
    check("loaduse_stall", stall_o, 1);
    adv();
    drive(0, 0, 0, 0, 0, 0, 2, 6, 0, "bubble");
    check("bubble_nostall", stall_o, 0);
    adv();
    drive(1, 2, 6, 7, 1, 0, 0, 0, 0, "consumer");
    check("loaduse_A_wb", fwdA_sel_o, 2);
`ifdef FWD_STALL_CNT_EN
    check("stall_cnt_one", stall_cnt_o, 1);
`endif
    adv();
    nops(2);

    drive(1, 0, 0, 0, 1, 1, 0, 0, 0, "wr_r0");
    check("r0_nostall", stall_o, 0);
    adv();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, "rd_r0");
    check("r0_selA", fwdA_sel_o, 0);
    check("r0_selB", fwdB_sel_o, 0);
    adv();
    nops(2);

    drive(1, 1, 1, 2, 1, 1, 2, 2, 1, "lw_flush");
    check("flush_nostall", stall_o, 0);
    adv();
    drive(1, 2, 2, 9, 1, 0, 0, 0, 0, "after_flush1");
    check("flush_noA_mem", fwdA_sel_o, 0);
    adv();
    drive(1, 2, 2, 9, 0, 0, 0, 0, 0, "after_flush2");
    check("flush_noB_wb", fwdB_sel_o, 0);
    adv();

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        drive(1, 1, 1, 7, 1, 0, 0, 0, 0, "pre_rst");
        adv();
        drive(1, 7, 7, 5, 1, 1, 5, 5, 0, "mid_rst_pre");
        rst_i = 1'b1;
        #1;
        hist.delete();
        cnt_m = 0;
        check("midrst_selA", fwdA_sel_o, 0);
        check("midrst_selB", fwdB_sel_o, 0);
        check("midrst_stall", stall_o, 0);
`ifdef FWD_STALL_CNT_EN
        check("midrst_cnt", stall_cnt_o, 0);
`endif
        adv();
        rst_i = 1'b0;
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 9) == 0, "rand");
      adv();
    end

    $display("protocol note: %0d cycles had a load in MEM matching an EX source", n_prot);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
